insn_sequencer: RTL and testbench
=================================

# insn_sequencer

Instruction sequencer for the NPU: on a start command it fetches 32-bit instruction words from main memory through a request/ready port. It executes control-flow instructions itself (end, jump, call, return, loop) and forwards every other instruction to the compute unit over a valid/ready command port. It sits between the host control register logic, the shared memory arbiter (read client) and the compute engine.

## Interface
Parameters:
- STACK_DEPTH, 4, return-address stack entries (power of two).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begin execution at addr.
- addr  in  16  start word address, sampled with start.
- busy  out  1  high while a program is running.
- smem_valid  out  1  fetch request; held until smem_ready.
- smem_ready  in  1  one-cycle pulse: smem_data valid this cycle.
- smem_addr  out  16  fetch address; stable while smem_valid.
- smem_data  in  32  fetched instruction word.
- comp_valid  out  1  instruction offered to compute.
- comp_ready  in  1  compute accepts when comp_valid && comp_ready.
- comp_insn  out  32  instruction to compute; stable while comp_valid.

## Operation
- Opcode is insn[31:26]. Target address is insn[15:0]. Loop count is insn[25:16].
- States: IDLE, FETCH, DECODE, ISSUE.
- IDLE:
  - start loads pc=addr, clears the loop register and the stack pointer, and goes to FETCH.
  - start while not IDLE is ignored.
- FETCH: smem_valid=1, smem_addr=pc. On smem_ready, latch smem_data and go to DECODE.
- DECODE: one cycle; executes the instruction by opcode.
  - 0x00 END: go to IDLE. Not forwarded.
  - 0x01 JUMP: pc=target, go to FETCH.
  - 0x02 CALL: push pc+2, pc=target, go to FETCH. Stack pointer wraps mod STACK_DEPTH, so overflow overwrites the oldest entry.
  - 0x03 RETURN:
    - Stack empty (depth counter 0): behaves as END.
    - Otherwise pop into pc and go to FETCH.
  - 0x04 LOOP (single, non-nesting loop register loop_active/loop_cnt):
    - If !loop_active and count==0: pc=pc+2.
    - If !loop_active and count!=0: loop_active=1, loop_cnt=count-1, pc=target.
    - If loop_active and loop_cnt==0: loop_active=0, pc=pc+2.
    - Otherwise: loop_cnt--, pc=target.
    - Net effect: a body ending in LOOP count=N executes N+1 times.
  - All other opcodes: go to ISSUE.
- ISSUE: comp_valid=1, comp_insn=latched word. On comp_ready, pc=pc+2 and go to FETCH.
- pc arithmetic: 16-bit, wraps modulo 2^16. Instruction slots are at even word addresses; pc always advances by 2.
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE; busy, smem_valid, comp_valid = 0; smem_addr, comp_insn = 0; stack pointer, depth counter and loop register cleared.
- Reset mid-operation aborts immediately, with no completion of an outstanding fetch or issue. A smem_ready arriving after reset is ignored.
- All outputs are registered.
- start sampled in cycle t gives busy=1, smem_valid=1, smem_addr=addr in cycle t+1.
- smem_ready in cycle k:
  - smem_valid drops in k+1 (DECODE).
  - A forwarded instruction has comp_valid=1 in k+2.
  - A control instruction gives the next smem_valid in k+2.
  - END gives busy=0 in k+2.
- Handshake in cycle h gives comp_valid=0 and smem_valid=1 (pc+2) in h+1.
- smem_ready outside FETCH and comp_ready outside ISSUE are ignored.
- Fetch latency is arbitrary (≥1 cycle). The arbiter may stall; nominal is 3 cycles after smem_valid rises.

## Test plan
- Reset mid-ISSUE, then start addr=0x0010 → comp_valid drops immediately after reset; the first fetch is at 0x0010 with busy=1.
- Program at 0x0000: 0x20000001, 0x20000002, 0x00000000; compute ready always; memory ready 3 cycles after request.
  - Compute receives exactly 0x20000001 then 0x20000002.
  - Fetch addresses are 0,2,4.
  - busy falls 2 cycles after the END fetch completes.
- Hold comp_ready low 5 cycles while ISSUE → comp_valid and comp_insn are stable throughout; no new fetch until the handshake.
- CALL 0x0040 at 0x0000, subroutine at 0x0040 = {0x20000AAA, RETURN}, END at 0x0002 → compute sees 0x20000AAA once; the fetch sequence is 0,0x40,0x42,2.
- Body {0x20000005 at 0x0010, LOOP count=3 target=0x0010 at 0x0012, END} → compute sees 0x20000005 four times, then busy=0.
- Start pulse while busy, and RETURN with an empty stack → the start is ignored with pc unaffected; the empty RETURN ends the program like END.

Source files
------------

// File: rtl/insn_sequencer.sv
// Instruction sequencer: fetches 32-bit words from memory, runs control flow locally
// (end/jump/call/return/loop) and forwards all other instructions to the compute unit.
module insn_sequencer #(
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] addr,
   output logic        busy,
   output logic        smem_valid,
   input  logic        smem_ready,
   output logic [15:0] smem_addr,
   input  logic [31:0] smem_data,
   output logic        comp_valid,
   input  logic        comp_ready,
   output logic [31:0] comp_insn
);

   localparam int unsigned SP_W    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

   localparam logic [5:0] OP_END    = 6'h00;
   localparam logic [5:0] OP_JUMP   = 6'h01;
   localparam logic [5:0] OP_CALL   = 6'h02;
   localparam logic [5:0] OP_RETURN = 6'h03;
   localparam logic [5:0] OP_LOOP   = 6'h04;

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DECODE, ST_ISSUE} state_t;

   state_t              state_q, state_d;
   logic [15:0]         pc_q, pc_d;
   logic [31:0]         insn_q, insn_d;
   logic [SP_W-1:0]     sp_q, sp_d;
   logic [DEPTH_W-1:0]  depth_q, depth_d;
   logic                loop_active_q, loop_active_d;
   logic [9:0]          loop_cnt_q, loop_cnt_d;
   logic [15:0]         stack_q [STACK_DEPTH];
   logic [15:0]         stack_d [STACK_DEPTH];
   logic                busy_q, busy_d;
   logic                smem_valid_q, smem_valid_d;
   logic [15:0]         smem_addr_q, smem_addr_d;
   logic                comp_valid_q, comp_valid_d;
   logic [31:0]         comp_insn_q, comp_insn_d;

   logic [5:0]          opcode;
   logic [15:0]         target;
   logic [9:0]          count;
   logic [15:0]         pc_next;
   logic [SP_W-1:0]     sp_prev;

   assign opcode  = insn_q[31:26];
   assign count   = insn_q[25:16];
   assign target  = insn_q[15:0];
   assign pc_next = pc_q + 16'd2;
   assign sp_prev = sp_q - SP_W'(1);

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      insn_d        = insn_q;
      sp_d          = sp_q;
      depth_d       = depth_q;
      loop_active_d = loop_active_q;
      loop_cnt_d    = loop_cnt_q;
      stack_d       = stack_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               pc_d          = addr;
               loop_active_d = 1'b0;
               loop_cnt_d    = '0;
               sp_d          = '0;
               depth_d       = '0;
               state_d       = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (smem_ready) begin
               insn_d  = smem_data;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            case (opcode)
               OP_END: state_d = ST_IDLE;
               OP_JUMP: begin
                  pc_d    = target;
                  state_d = ST_FETCH;
               end
               OP_CALL: begin
                  // The stack is circular; depth saturates so overflow silently drops the oldest entry.
                  stack_d[sp_q] = pc_next;
                  sp_d          = sp_q + SP_W'(1);
                  if (depth_q != DEPTH_MAX) depth_d = depth_q + DEPTH_W'(1);
                  pc_d          = target;
                  state_d       = ST_FETCH;
               end
               OP_RETURN: begin
                  if (depth_q == '0) begin
                     state_d = ST_IDLE;
                  end else begin
                     pc_d    = stack_q[sp_prev];
                     sp_d    = sp_prev;
                     depth_d = depth_q - DEPTH_W'(1);
                     state_d = ST_FETCH;
                  end
               end
               OP_LOOP: begin
                  state_d = ST_FETCH;
                  if (!loop_active_q) begin
                     if (count == '0) begin
                        pc_d = pc_next;
                     end else begin
                        loop_active_d = 1'b1;
                        loop_cnt_d    = count - 10'd1;
                        pc_d          = target;
                     end
                  end else if (loop_cnt_q == '0) begin
                     loop_active_d = 1'b0;
                     pc_d          = pc_next;
                  end else begin
                     loop_cnt_d = loop_cnt_q - 10'd1;
                     pc_d       = target;
                  end
               end
               default: state_d = ST_ISSUE;
            endcase
         end
         ST_ISSUE: begin
            if (comp_ready) begin
               pc_d    = pc_next;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next-state view so they align with the state they describe.
   always_comb begin
      busy_d       = (state_d != ST_IDLE);
      smem_valid_d = (state_d == ST_FETCH);
      smem_addr_d  = (state_d == ST_FETCH) ? pc_d : smem_addr_q;
      comp_valid_d = (state_d == ST_ISSUE);
      comp_insn_d  = (state_d == ST_ISSUE) ? insn_q : comp_insn_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pc_q          <= '0;
         insn_q        <= '0;
         sp_q          <= '0;
         depth_q       <= '0;
         loop_active_q <= 1'b0;
         loop_cnt_q    <= '0;
         stack_q       <= '{default: '0};
         busy_q        <= 1'b0;
         smem_valid_q  <= 1'b0;
         smem_addr_q   <= '0;
         comp_valid_q  <= 1'b0;
         comp_insn_q   <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         insn_q        <= insn_d;
         sp_q          <= sp_d;
         depth_q       <= depth_d;
         loop_active_q <= loop_active_d;
         loop_cnt_q    <= loop_cnt_d;
         stack_q       <= stack_d;
         busy_q        <= busy_d;
         smem_valid_q  <= smem_valid_d;
         smem_addr_q   <= smem_addr_d;
         comp_valid_q  <= comp_valid_d;
         comp_insn_q   <= comp_insn_d;
      end
   end

   assign busy       = busy_q;
   assign smem_valid = smem_valid_q;
   assign smem_addr  = smem_addr_q;
   assign comp_valid = comp_valid_q;
   assign comp_insn  = comp_insn_q;

endmodule

// File: tb/tb_insn_sequencer.sv
// Scoreboard bench for insn_sequencer: expected fetch addresses and compute words are queued
// when each program is loaded and popped as the memory/compute models observe the DUT.
module tb_insn_sequencer;

   localparam int MEM_LAT = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] addr;
   logic        busy;
   logic        smem_valid;
   logic        smem_ready;
   logic [15:0] smem_addr;
   logic [31:0] smem_data;
   logic        comp_valid;
   logic        comp_ready;
   logic [31:0] comp_insn;

   logic [31:0] mem [0:255];
   logic [15:0] exp_fetch [$];
   logic [31:0] exp_comp [$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_ready_cyc = 0;
   int wait_cnt = 0;

   insn_sequencer #(.STACK_DEPTH(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .addr       (addr),
      .busy       (busy),
      .smem_valid (smem_valid),
      .smem_ready (smem_ready),
      .smem_addr  (smem_addr),
      .smem_data  (smem_data),
      .comp_valid (comp_valid),
      .comp_ready (comp_ready),
      .comp_insn  (comp_insn)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
      end
   endtask

   // Memory responder plus output monitors, evaluated just after the falling edge.
   initial begin
      smem_ready = 1'b0;
      smem_data  = '0;
      forever begin
         @(negedge clock);
         #1;
         if (!reset && comp_valid && comp_ready) begin
            if (exp_comp.size() == 0) chk("comp_extra", comp_insn, ~comp_insn);
            else chk("comp_insn", comp_insn, exp_comp.pop_front());
         end
         if (smem_ready) begin
            smem_ready = 1'b0;
            wait_cnt   = 0;
         end else if (!reset && smem_valid) begin
            wait_cnt++;
            if (wait_cnt >= MEM_LAT) begin
               smem_ready     = 1'b1;
               smem_data      = mem[smem_addr[7:0]];
               last_ready_cyc = cyc;
               if (exp_fetch.size() == 0) chk("fetch_extra", {16'h0, smem_addr}, {16'hffff, smem_addr});
               else chk("fetch_addr", {16'h0, smem_addr}, {16'h0, exp_fetch.pop_front()});
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic start_prog(input logic [15:0] a);
      @(negedge clock);
      start = 1'b1;
      addr  = a;
      @(negedge clock);
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_smem_valid", 32'(smem_valid), 32'd1);
      chk("start_smem_addr", {16'h0, smem_addr}, {16'h0, a});
   endtask

   task automatic wait_comp_valid(input string tag);
      int n = 0;
      while (!comp_valid && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk(tag, 32'(comp_valid), 32'd1);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (busy && n < 500) begin
         @(negedge clock);
         n++;
      end
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      chk({tag, "_end_latency"}, 32'(cyc - last_ready_cyc), 32'd2);
      chk({tag, "_comp_left"}, 32'(exp_comp.size()), 32'd0);
      chk({tag, "_fetch_left"}, 32'(exp_fetch.size()), 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      addr       = '0;
      comp_ready = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (3) @(negedge clock);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_smem_valid", 32'(smem_valid), 32'd0);
      chk("rst_comp_valid", 32'(comp_valid), 32'd0);
      chk("rst_smem_addr", {16'h0, smem_addr}, 32'd0);
      chk("rst_comp_insn", comp_insn, 32'd0);
      reset = 1'b0;

      // Straight-line program ending in END
      mem[8'h00] = 32'h2000_0001;
      mem[8'h02] = 32'h2000_0002;
      mem[8'h04] = 32'h0000_0000;
      exp_fetch.push_back(16'h0000);
      exp_fetch.push_back(16'h0002);
      exp_fetch.push_back(16'h0004);
      exp_comp.push_back(32'h2000_0001);
      exp_comp.push_back(32'h2000_0002);
      start_prog(16'h0000);
      drain("linear");

      // Compute back-pressure holds ISSUE stable
      mem[8'h20] = 32'h2000_0033;
      mem[8'h22] = 32'h0000_0000;
      exp_fetch.push_back(16'h0020);
      exp_fetch.push_back(16'h0022);
      exp_comp.push_back(32'h2000_0033);
      comp_ready = 1'b0;
      start_prog(16'h0020);
      wait_comp_valid("stall_reach");
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(comp_valid), 32'd1);
         chk("stall_insn", comp_insn, 32'h2000_0033);
         chk("stall_nofetch", 32'(smem_valid), 32'd0);
         @(negedge clock);
      end
      comp_ready = 1'b1;
      @(negedge clock);
      chk("hs_comp_drop", 32'(comp_valid), 32'd0);
      chk("hs_fetch", 32'(smem_valid), 32'd1);
      chk("hs_fetch_addr", {16'h0, smem_addr}, 32'h0000_0022);
      drain("stall");

      // CALL / RETURN
      mem[8'h00] = 32'h0800_0040;
      mem[8'h02] = 32'h0000_0000;
      mem[8'h40] = 32'h2000_0AAA;
      mem[8'h42] = 32'h0C00_0000;
      exp_fetch.push_back(16'h0000);
      exp_fetch.push_back(16'h0040);
      exp_fetch.push_back(16'h0042);
      exp_fetch.push_back(16'h0002);
      exp_comp.push_back(32'h2000_0AAA);
      start_prog(16'h0000);
      drain("call");

      // Start ignored while busy; JUMP; RETURN on empty stack ends the program
      mem[8'h30] = 32'h2000_0077;
      mem[8'h32] = 32'h0400_0060;
      mem[8'h60] = 32'h0C00_0000;
      exp_fetch.push_back(16'h0030);
      exp_fetch.push_back(16'h0032);
      exp_fetch.push_back(16'h0060);
      exp_comp.push_back(32'h2000_0077);
      start_prog(16'h0030);
      @(negedge clock);
      start = 1'b1;
      addr  = 16'h0100;
      @(negedge clock);
      start = 1'b0;
      chk("busy_start_addr", {16'h0, smem_addr}, 32'h0000_0030);
      drain("empty_ret");

      // Reset while ISSUE is pending
      mem[8'h50] = 32'h2000_0099;
      mem[8'h52] = 32'h0000_0000;
      exp_fetch.push_back(16'h0050);
      comp_ready = 1'b0;
      start_prog(16'h0050);
      wait_comp_valid("rst_issue_reach");
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_comp_valid", 32'(comp_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_smem_valid", 32'(smem_valid), 32'd0);
      reset      = 1'b0;
      comp_ready = 1'b1;

      // Loop body runs count+1 times
      mem[8'h10] = 32'h2000_0005;
      mem[8'h12] = 32'h1003_0010;
      mem[8'h14] = 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
         exp_fetch.push_back(16'h0010);
         exp_fetch.push_back(16'h0012);
         exp_comp.push_back(32'h2000_0005);
      end
      exp_fetch.push_back(16'h0014);
      start_prog(16'h0010);
      drain("loop");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
